// File: rtl/fruit_pkg.sv
// ----------------------------------------------------------------------------
// fruit_pkg
// Shared definitions for the per-fruit kinematics stage: screen and sprite
// defaults, the FSM state type, the signed position type and a helper that
// widens an 8-bit signed velocity to position width.
// ----------------------------------------------------------------------------
package fruit_pkg;

    localparam int SCREEN_W_DEF   = 640;
    localparam int SCREEN_H_DEF   = 480;
    localparam int FRUIT_SX_DEF   = 32;
    localparam int FRUIT_SY_DEF   = 32;
    localparam int GRAV_DEF       = 1;
    localparam int GRAV_DIV_DEF   = 2;
    localparam int SLICE_HOLD_DEF = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLY    = 2'd1,
        SLICED = 2'd2
    } fruit_state_t;

    typedef logic signed [11:0] pos_t;

    // Sign-extend an 8-bit two's-complement velocity to position width.
    function automatic pos_t sext_vel(input logic [7:0] v);
        return pos_t'($signed(v));
    endfunction

endpackage

// File: rtl/fruit_integrator.sv
// ----------------------------------------------------------------------------
// fruit_integrator
// Holds the fruit position (x, y) and velocity (vx, vy) plus the gravity
// divider. A load presets the launch state; a step advances one frame using
// the current velocity, then applies gravity every GRAV_DIV-th step.
// o_retire reports whether the position/velocity after the pending step
// leaves the screen; it is only meaningful together with i_step.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_load              preset x=launch_x, y=SCREEN_H, vx/vy, gcnt=0
//   i_step              advance one frame (ignored when i_load is high)
//   i_launch_x/vx/vy    launch values (x unsigned, velocities signed)
//   o_pos_x, o_pos_y    low 10 bits of the registered position
//   o_retire            post-step position/velocity is off screen
// ----------------------------------------------------------------------------
module fruit_integrator
    import fruit_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int FRUIT_SX = FRUIT_SX_DEF,
    parameter int GRAV     = GRAV_DEF,
    parameter int GRAV_DIV = GRAV_DIV_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [9:0] i_launch_x,
    input  logic [7:0] i_launch_vx,
    input  logic [7:0] i_launch_vy,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y,
    output logic       o_retire
);

    localparam pos_t       X_LEFT    = pos_t'(-FRUIT_SX);
    localparam pos_t       X_RIGHT   = pos_t'(SCREEN_W);
    localparam pos_t       Y_BOTTOM  = pos_t'(SCREEN_H);
    localparam logic [3:0] GCNT_LAST = 4'(GRAV_DIV - 1);
    localparam logic [7:0] GRAV_STEP = 8'(GRAV);

    pos_t       r_x;
    pos_t       r_y;
    logic [7:0] r_vx;
    logic [7:0] r_vy;
    logic [3:0] r_gcnt;

    pos_t       w_next_x;
    pos_t       w_next_y;
    logic [7:0] w_next_vy;
    logic [3:0] w_next_gcnt;
    logic       w_grav;
    logic       w_falling;
    logic       w_off_side;

    // Position moves with the velocity held before this frame's gravity,
    // so gravity takes effect on the following frame.
    always_comb begin
        w_next_x    = r_x + sext_vel(r_vx);
        w_next_y    = r_y - sext_vel(r_vy);
        w_grav      = (r_gcnt == GCNT_LAST);
        w_next_vy   = w_grav ? (r_vy - GRAV_STEP) : r_vy;
        w_next_gcnt = w_grav ? 4'd0 : (r_gcnt + 4'd1);
        // Falling check needs vy<=0 so a fresh launch from the bottom edge
        // (y == SCREEN_H, moving up) is not retired.
        w_falling   = ($signed(w_next_vy) <= 8'sd0) && (w_next_y >= Y_BOTTOM);
        w_off_side  = (w_next_x <= X_LEFT) || (w_next_x >= X_RIGHT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_vx   <= '0;
            r_vy   <= '0;
            r_gcnt <= '0;
        end else if (i_load) begin
            r_x    <= {2'b00, i_launch_x};
            r_y    <= Y_BOTTOM;
            r_vx   <= i_launch_vx;
            r_vy   <= i_launch_vy;
            r_gcnt <= '0;
        end else if (i_step) begin
            r_x    <= w_next_x;
            r_y    <= w_next_y;
            r_vy   <= w_next_vy;
            r_gcnt <= w_next_gcnt;
        end
    end

    // Negative x wraps modulo 1024; the downstream mapper relies on that.
    assign o_pos_x  = r_x[9:0];
    assign o_pos_y  = r_y[9:0];
    assign o_retire = w_falling || w_off_side;

endmodule

// File: rtl/fruit_motion.sv
// ----------------------------------------------------------------------------
// fruit_motion
// Per-fruit kinematics stage feeding color_mapper. Launches a fruit from the
// bottom edge, integrates it once per frame, tracks slicing and retires the
// fruit when it leaves the screen or after the slice hold time.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   frame_tick          one-Clk pulse per frame
//   launch              launch request, taken only in IDLE
//   launch_x/vx/vy      launch position (unsigned) and velocities (signed)
//   slice_hit           blade overlap strobe, taken only in FLY
//   fruitX/fruitY       sprite top-left, low 10 bits of signed position
//   fruitSX/fruitSY     sprite size while active, else 0
//   active, sliced      state flags
//   slice_pulse         one Clk on entry to SLICED
//   miss_pulse          one Clk when an unsliced fruit retires
//   dbg_state           current FSM state (fruit_state_t encoding)
// All outputs are registered: they change one Clk after the causing input.
// ----------------------------------------------------------------------------
module fruit_motion
    import fruit_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int FRUIT_SX   = FRUIT_SX_DEF,
    parameter int FRUIT_SY   = FRUIT_SY_DEF,
    parameter int GRAV       = GRAV_DEF,
    parameter int GRAV_DIV   = GRAV_DIV_DEF,
    parameter int SLICE_HOLD = SLICE_HOLD_DEF
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [9:0] launch_x,
    input  logic [7:0] launch_vx,
    input  logic [7:0] launch_vy,
    input  logic       slice_hit,
    output logic [9:0] fruitX,
    output logic [9:0] fruitY,
    output logic [9:0] fruitSX,
    output logic [9:0] fruitSY,
    output logic       active,
    output logic       sliced,
    output logic       slice_pulse,
    output logic       miss_pulse,
    output logic [1:0] dbg_state
);

    localparam logic [9:0] SX10      = 10'(FRUIT_SX);
    localparam logic [9:0] SY10      = 10'(FRUIT_SY);
    localparam logic [4:0] HOLD_LAST = 5'(SLICE_HOLD - 1);

    fruit_state_t r_state;
    logic [4:0]   r_hcnt;

    logic w_load;
    logic w_step;
    logic w_retire;

    // A launch cycle only loads; a frame_tick in that same cycle is dropped.
    assign w_load = (r_state == IDLE) && launch;
    assign w_step = (r_state != IDLE) && frame_tick;

    fruit_integrator #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .FRUIT_SX (FRUIT_SX),
        .GRAV     (GRAV),
        .GRAV_DIV (GRAV_DIV)
    ) u_integrator (
        .i_clk       (Clk),
        .i_rst_n     (Reset_n),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_launch_x  (launch_x),
        .i_launch_vx (launch_vx),
        .i_launch_vy (launch_vy),
        .o_pos_x     (fruitX),
        .o_pos_y     (fruitY),
        .o_retire    (w_retire)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_hcnt      <= '0;
            active      <= 1'b0;
            sliced      <= 1'b0;
            slice_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            fruitSX     <= '0;
            fruitSY     <= '0;
        end else begin
            slice_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (launch) begin
                        r_state <= FLY;
                        active  <= 1'b1;
                        fruitSX <= SX10;
                        fruitSY <= SY10;
                    end
                end
                FLY: begin
                    // Leaving the screen outranks a slice in the same cycle.
                    if (frame_tick && w_retire) begin
                        r_state    <= IDLE;
                        active     <= 1'b0;
                        fruitSX    <= '0;
                        fruitSY    <= '0;
                        miss_pulse <= 1'b1;
                    end else if (slice_hit) begin
                        r_state     <= SLICED;
                        sliced      <= 1'b1;
                        r_hcnt      <= '0;
                        slice_pulse <= 1'b1;
                    end
                end
                SLICED: begin
                    if (frame_tick) begin
                        if (w_retire || (r_hcnt == HOLD_LAST)) begin
                            r_state <= IDLE;
                            active  <= 1'b0;
                            sliced  <= 1'b0;
                            fruitSX <= '0;
                            fruitSY <= '0;
                        end else begin
                            r_hcnt <= r_hcnt + 5'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    active  <= 1'b0;
                    sliced  <= 1'b0;
                    fruitSX <= '0;
                    fruitSY <= '0;
                end
            endcase
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_fruit_motion.sv
module tb_fruit_motion;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int FRUIT_SX   = 32;
    localparam int GRAV       = 1;
    localparam int GRAV_DIV   = 2;
    localparam int SLICE_HOLD = 20;

    // ---------------- clock / reset ----------------
    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       launch     = 1'b0;
    logic [9:0] launch_x   = '0;
    logic [7:0] launch_vx  = '0;
    logic [7:0] launch_vy  = '0;
    logic       slice_hit  = 1'b0;

    logic [9:0] fruitX;
    logic [9:0] fruitY;
    logic [9:0] fruitSX;
    logic [9:0] fruitSY;
    logic       active;
    logic       sliced;
    logic       slice_pulse;
    logic       miss_pulse;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fruit_motion dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .frame_tick  (frame_tick),
        .launch      (launch),
        .launch_x    (launch_x),
        .launch_vx   (launch_vx),
        .launch_vy   (launch_vy),
        .slice_hit   (slice_hit),
        .fruitX      (fruitX),
        .fruitY      (fruitY),
        .fruitSX     (fruitSX),
        .fruitSY     (fruitSY),
        .active      (active),
        .sliced      (sliced),
        .slice_pulse (slice_pulse),
        .miss_pulse  (miss_pulse),
        .dbg_state   (dbg_state)
    );

    // ---------------- behavioural model ----------------
    // Tracks the fruit in plain integers: velocity is derived from the frame
    // count since launch rather than kept as a decrementing register.
    int   m_x = 0, m_y = 0, m_vx = 0, m_vy0 = 0, m_k = 0, m_h = 0;
    int   m_mode = 0;   // 0 = on shelf, 1 = flying, 2 = cut
    logic m_sp = 1'b0, m_mp = 1'b0;
    logic [43:0] exp_q[$];

    function automatic int vy_after(input int vy0, input int k);
        return vy0 - GRAV * (k / GRAV_DIV);
    endfunction

    always @(posedge clk) begin : model
        int vy_now;
        bit off;
        logic [9:0] sz;
        m_sp = 1'b0;
        m_mp = 1'b0;
        off  = 1'b0;
        if (!rst_n) begin
            m_x = 0; m_y = 0; m_vx = 0; m_vy0 = 0; m_k = 0; m_h = 0; m_mode = 0;
        end else if (m_mode == 0) begin
            if (launch) begin
                m_x    = int'(launch_x);
                m_y    = SCREEN_H;
                m_vx   = int'($signed(launch_vx));
                m_vy0  = int'($signed(launch_vy));
                m_k    = 0;
                m_mode = 1;
            end
        end else begin
            if (frame_tick) begin
                vy_now = vy_after(m_vy0, m_k);
                m_x = m_x + m_vx;
                m_y = m_y - vy_now;
                m_k = m_k + 1;
                off = ((vy_after(m_vy0, m_k) <= 0) && (m_y >= SCREEN_H)) ||
                      (m_x <= -FRUIT_SX) || (m_x >= SCREEN_W);
            end
            if (m_mode == 1) begin
                if (off) begin
                    m_mode = 0;
                    m_mp   = 1'b1;
                end else if (slice_hit) begin
                    m_mode = 2;
                    m_h    = 0;
                    m_sp   = 1'b1;
                end
            end else if (frame_tick) begin
                m_h = m_h + 1;
                if (off || (m_h == SLICE_HOLD)) m_mode = 0;
            end
        end
        sz = (m_mode != 0) ? 10'd32 : 10'd0;
        exp_q.push_back({m_x[9:0], m_y[9:0], sz, sz,
                         (m_mode != 0), (m_mode == 2), m_sp, m_mp});
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : compare
        logic [43:0] e;
        logic [43:0] g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst_n) e = '0;
            g = {fruitX, fruitY, fruitSX, fruitSY, active, sliced, slice_pulse, miss_pulse};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL cycle_compare t=%0t got=%h exp=%h", $time, g, e);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic l, input logic [9:0] lx, input logic [7:0] vx,
                       input logic [7:0] vy, input logic t, input logic h);
        launch = l; launch_x = lx; launch_vx = vx; launch_vy = vy;
        frame_tick = t; slice_hit = h;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 10'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b0, 10'd0, 8'd0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic do_launch(input logic [9:0] lx, input logic [7:0] vx, input logic [7:0] vy);
        cyc(1'b1, lx, vx, vy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        launch = 1'b0; frame_tick = 1'b0; slice_hit = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin : watchdog
        #100000;
        n_err++;
        $display("FAIL watchdog time limit reached");
        summary();
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin : main
        // 1: reset held with launch requested
        rst_n = 1'b0; launch = 1'b1; launch_x = 10'd123; launch_vx = 8'd5; launch_vy = 8'd5;
        repeat (3) @(negedge clk);
        chk("rst_active", active, 0);
        chk("rst_fruitSX", fruitSX, 0);
        chk("rst_fruitX", fruitX, 0);
        launch = 1'b0;
        rst_n  = 1'b1;
        idle(2);
        chk("post_rst_fruitSX", fruitSX, 0);
        chk("post_rst_active", active, 0);

        // 2: launch x=300 vx=2 vy=20
        do_launch(10'd300, 8'd2, 8'd20);
        chk("launch_fruitX", fruitX, 300);
        chk("launch_fruitY", fruitY, 480);
        chk("launch_fruitSX", fruitSX, 32);
        tick();
        chk("tick1_x", fruitX, 302);
        chk("tick1_y", fruitY, 460);
        idle(1);
        tick();
        chk("tick2_x", fruitX, 304);
        chk("tick2_y", fruitY, 440);
        idle(1);
        tick();
        chk("tick3_y_grav", fruitY, 421);

        // 3: slice, then hold for 20 frames
        cyc(1'b0, 10'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        chk("slice_pulse_hi", slice_pulse, 1);
        chk("sliced_hi", sliced, 1);
        idle(1);
        chk("slice_pulse_lo", slice_pulse, 0);
        repeat (19) begin tick(); idle(1); end
        chk("hold19_active", active, 1);
        tick();
        chk("hold20_active", active, 0);
        chk("hold20_fruitSX", fruitSX, 0);
        chk("hold20_miss", miss_pulse, 0);
        idle(1);

        // 4: miss after falling back out
        do_launch(10'd100, 8'd0, 8'd5);
        repeat (21) begin tick(); idle(1); end
        chk("fall21_active", active, 1);
        chk("fall21_y", fruitY, 475);
        tick();
        chk("fall_miss_pulse", miss_pulse, 1);
        chk("fall_active", active, 0);
        chk("fall_y", fruitY, 480);
        idle(1);
        chk("fall_miss_once", miss_pulse, 0);

        // 5a: launch while flying is ignored
        do_launch(10'd200, 8'd1, 8'd10);
        cyc(1'b1, 10'd500, 8'hFB, 8'd50, 1'b0, 1'b0);
        chk("relaunch_ignored_x", fruitX, 200);
        tick();
        chk("relaunch_tick_x", fruitX, 201);
        chk("relaunch_tick_y", fruitY, 470);
        do_reset();
        idle(1);

        // 5a: slice while idle is ignored
        cyc(1'b0, 10'd0, 8'd0, 8'd0, 1'b1, 1'b1);
        chk("idle_slice_pulse", slice_pulse, 0);
        chk("idle_slice_sliced", sliced, 0);

        // 5b: slice on the exit tick counts as a miss
        do_launch(10'd620, 8'd20, 8'd10);
        cyc(1'b0, 10'd0, 8'd0, 8'd0, 1'b1, 1'b1);
        chk("exit_slice_miss", miss_pulse, 1);
        chk("exit_slice_nopulse", slice_pulse, 0);
        chk("exit_slice_active", active, 0);
        chk("exit_slice_x", fruitX, 640);
        idle(1);

        // 5c: vx=-128 from x=0 leaves on the first tick, x wraps
        do_launch(10'd0, 8'h80, 8'd10);
        tick();
        chk("left_exit_x", fruitX, 10'h380);
        chk("left_exit_miss", miss_pulse, 1);
        chk("left_exit_active", active, 0);
        idle(1);

        // 6: asynchronous reset while sliced
        do_launch(10'd50, 8'd3, 8'd30);
        tick(); idle(1);
        cyc(1'b0, 10'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        repeat (3) begin tick(); idle(1); end
        chk("pre_rst_sliced", sliced, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_active", active, 0);
        chk("async_rst_sliced", sliced, 0);
        chk("async_rst_fruitX", fruitX, 0);
        chk("async_rst_fruitSX", fruitSX, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        do_launch(10'd400, 8'hFF, 8'd15);
        chk("after_rst_launch_x", fruitX, 400);
        chk("after_rst_active", active, 1);
        tick();
        chk("after_rst_tick_x", fruitX, 399);
        chk("after_rst_tick_y", fruitY, 465);
        idle(3);

        summary();
        $finish;
    end

endmodule
